// File: rtl/ssd_pkg.sv
// ssd_pkg: shared seven-segment glyph constants and segment-order helper
package ssd_pkg;
  localparam logic [6:0] SSD_BLANK = 7'b1111111;
  localparam logic [15:0][6:0] SSD_GLYPH = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } ssd_pins_t;
  function automatic logic [6:0] ssd_reorder(input logic [6:0] x);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = x[6-i];
    return r;
  endfunction
endpackage

// File: rtl/ssd_capture4_if.sv
// ssd_capture4_if: SSD pin inputs and decoded capture outputs
interface ssd_capture4_if;
  logic [6:0] seg;
  logic [3:0] an;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic [3:0] valid;
  logic [3:0] blank;
  logic frame_done;
  logic glyph_err;
  logic timeout;
  modport master(output seg, an, input digit3, digit2, digit1, digit0, valid, blank, frame_done, glyph_err, timeout);
  modport slave(input seg, an, output digit3, digit2, digit1, digit0, valid, blank, frame_done, glyph_err, timeout);
endinterface

// File: rtl/ssd_glyph_decode.sv
// ssd_glyph_decode: abcdefg glyph to hex nibble with legal/blank flags
module ssd_glyph_decode
  import ssd_pkg::*;
(
  input  logic [6:0] abcdefg,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       is_blank
);
  assign is_blank = abcdefg == SSD_BLANK;
  always_comb begin
    nibble = '0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++)
      if (abcdefg == SSD_GLYPH[i]) begin
        nibble = 4'(i);
        legal = 1'b1;
      end
  end
endmodule

// File: rtl/ssd_capture4.sv
// ssd_capture4: samples multiplexed 4-digit SSD drive and decodes digits
module ssd_capture4
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT = 262144
) (
  input logic clk,
  input logic rst,
  ssd_capture4_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  ssd_pins_t pins, in_q;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic armed, chg, cap, fd, to, legal, is_blank;
  logic [3:0] seen, cap_bit, nib, valid, blank;
  logic [3:0][3:0] dig;
  logic frame_done, glyph_err, timeout;
  logic [6:0] abc;
  assign pins = '{an: bus.an, seg: bus.seg};
  assign chg = pins != in_q;
  assign cap = armed && cnt == CMAX && $onehot(~in_q.an);
  assign cap_bit = cap ? ~in_q.an : 4'h0;
  assign fd = cap && (seen | cap_bit) == 4'hF;
  assign to = !fd && tcnt == TMAX;
  assign abc = ssd_reorder(in_q.seg);
  ssd_glyph_decode u_dec (
    .abcdefg(abc),
    .nibble(nib),
    .legal(legal),
    .is_blank(is_blank)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= '{an: 4'hF, seg: 7'h7F};
      cnt <= '0;
      armed <= 1'b0;
      seen <= '0;
      tcnt <= '0;
      dig <= '0;
      valid <= '0;
      blank <= '0;
      frame_done <= 1'b0;
      glyph_err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      in_q <= pins;
      cnt <= chg ? '0 : (cnt == CMAX ? cnt : cnt + 1'b1);
      armed <= chg | (armed & ~cap);
      for (int i = 0; i < 4; i++)
        if (cap_bit[i]) begin
          if (legal) dig[i] <= nib;
          valid[i] <= legal;
          blank[i] <= is_blank;
        end
      if (to) valid <= '0;
      seen <= (fd || to) ? 4'h0 : seen | cap_bit;
      tcnt <= (fd || to) ? '0 : tcnt + 1'b1;
      frame_done <= fd;
      glyph_err <= cap && !legal && !is_blank;
      timeout <= to;
    end
  end
  assign bus.digit0 = dig[0];
  assign bus.digit1 = dig[1];
  assign bus.digit2 = dig[2];
  assign bus.digit3 = dig[3];
  assign bus.valid = valid;
  assign bus.blank = blank;
  assign bus.frame_done = frame_done;
  assign bus.glyph_err = glyph_err;
  assign bus.timeout = timeout;
endmodule

// File: tb/tb_ssd_capture4.sv
// tb_ssd_capture4: randomized and directed checks against a sliding-window reference model
module tb_ssd_capture4;
  localparam int S = 4;
  localparam int TO = 1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ssd_capture4_if bus();
  ssd_capture4 #(.STABLE_CYCLES(S), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [6:0] tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int to_cnt = 0;
  logic [10:0] hist[$];
  logic [3:0] m_dig [4];
  logic [3:0] m_valid, m_blank, m_seen;
  logic m_fd, m_ge, m_to;
  int m_since;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] flip(input logic [6:0] x);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = x[6-i];
    return r;
  endfunction
  function automatic logic [6:0] seg_of(input int d);
    return flip(tbl[d]);
  endfunction
  task automatic step(input logic r, input logic [3:0] a, input logic [6:0] s);
    logic [10:0] cur;
    logic [6:0] abc;
    logic cap;
    int pos, idx;
    rst = r;
    bus.an = a;
    bus.seg = s;
    @(posedge clk);
    cur = hist[hist.size()-1];
    cap = !r && $countones(~cur[10:7]) == 1 && hist[0] != cur;
    for (int i = 0; i < S; i++) if (hist[hist.size()-1-i] != cur) cap = 1'b0;
    hist.push_back(r ? 11'h7FF : {a, s});
    void'(hist.pop_front());
    m_fd = 1'b0;
    m_ge = 1'b0;
    m_to = 1'b0;
    if (r) begin
      for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
      m_valid = 4'h0;
      m_blank = 4'h0;
      m_seen = 4'h0;
      m_since = 0;
    end else begin
      if (cap) begin
        pos = 0;
        for (int i = 0; i < 4; i++) if (!cur[7+i]) pos = i;
        abc = flip(cur[6:0]);
        idx = -1;
        for (int d = 0; d < 16; d++) if (tbl[d] == abc) idx = d;
        if (idx >= 0) begin
          m_dig[pos] = 4'(idx);
          m_valid[pos] = 1'b1;
          m_blank[pos] = 1'b0;
        end else if (abc == 7'h7F) begin
          m_valid[pos] = 1'b0;
          m_blank[pos] = 1'b1;
        end else begin
          m_ge = 1'b1;
          m_valid[pos] = 1'b0;
          m_blank[pos] = 1'b0;
        end
        m_seen[pos] = 1'b1;
        if (m_seen == 4'hF) begin
          m_fd = 1'b1;
          m_seen = 4'h0;
        end
      end
      if (m_fd) m_since = 0;
      else if (m_since == TO - 1) begin
        m_to = 1'b1;
        m_valid = 4'h0;
        m_seen = 4'h0;
        m_since = 0;
      end else m_since++;
    end
    #1;
    if (bus.frame_done) fd_cnt++;
    if (bus.timeout) to_cnt++;
    check("digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    check("valid", bus.valid, m_valid);
    check("blank", bus.blank, m_blank);
    check("pulses", {bus.frame_done, bus.glyph_err, bus.timeout}, {m_fd, m_ge, m_to});
  endtask
  task automatic hold(input int n, input logic [3:0] a, input logic [6:0] s);
    for (int i = 0; i < n; i++) step(1'b0, a, s);
  endtask
  initial begin
    int vals[4] = '{1, 2, 3, 15};
    int f0, t0, guard;
    logic [3:0] a;
    logic [6:0] s;
    for (int i = 0; i <= S; i++) hist.push_back(11'h7FF);
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_valid = 4'h0;
    m_blank = 4'h0;
    m_seen = 4'h0;
    m_since = 0;
    step(1'b1, 4'hF, 7'h7F);
    step(1'b1, 4'b1110, seg_of(10));
    hold(12, 4'b1110, seg_of(10));
    check("static_a_digit0", bus.digit0, 4'hA);
    check("static_a_valid", bus.valid, 4'b0001);
    for (int f = 0; f < 6; f++) begin
      if (f == 2) f0 = fd_cnt;
      for (int p = 0; p < 4; p++) hold(64, ~(4'b1 << p), seg_of(vals[p]));
    end
    check("rot_frames", fd_cnt - f0, 4);
    check("rot_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'hF321);
    check("rot_valid", bus.valid, 4'hF);
    for (int i = 0; i < 20; i++) begin
      hold(2, 4'b1101, seg_of(5));
      hold(2, 4'b1101, seg_of(6));
    end
    check("glitch_digit1", bus.digit1, 4'h2);
    hold(10, 4'b1011, flip(7'b1111110));
    check("illegal_digit2", bus.digit2, 4'h3);
    check("illegal_valid2", bus.valid[2], 1'b0);
    hold(10, 4'b1101, 7'h7F);
    check("blank1", bus.blank[1], 1'b1);
    hold(2, 4'b1110, seg_of(3));
    step(1'b1, 4'b1110, seg_of(3));
    hold(8, 4'b1110, seg_of(3));
    for (int ph = 0; ph < 300; ph++) begin
      a = ($urandom_range(0, 4) != 0) ? ~(4'b1 << $urandom_range(0, 3)) : 4'($urandom);
      case ($urandom_range(0, 19))
        0, 1, 2: s = 7'h7F;
        3, 4, 5, 6: s = 7'($urandom);
        default: s = seg_of($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 49) == 0) step(1'b1, a, s);
      hold($urandom_range(1, 12), a, s);
    end
    t0 = to_cnt;
    hold(1100, 4'hF, 7'h7F);
    check("stall_timeout", to_cnt - t0, 1);
    check("stall_valid", bus.valid, 4'h0);
    guard = 0;
    while (!m_to && guard < 1100) begin
      step(1'b0, 4'hF, 7'h7F);
      guard++;
    end
    for (int p = 0; p < 3; p++) hold(S + 2, ~(4'b1 << p), seg_of(p + 7));
    guard = 0;
    while (m_since != TO - 1 - S && guard < 1100) begin
      step(1'b0, 4'hF, 7'h7F);
      guard++;
    end
    f0 = fd_cnt;
    t0 = to_cnt;
    hold(S + 3, 4'b0111, seg_of(9));
    check("coinc_frame", fd_cnt - f0, 1);
    check("coinc_timeout", to_cnt - t0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ssd_capture4.md
# ssd_capture4

Seven-segment display capture block: the receiving end of the 4-digit multiplexed SSD drive. It samples the active-low `seg`/`an` lines driven by a display controller, waits for each multiplexed phase to settle, and decodes the glyph back to a 4-bit hex digit per anode. It also reports blanked digits, illegal glyphs, completed refresh frames and refresh stalls. It sits in standalone test benches and loop-back hardware tests, so a display path can be checked without a camera or a human.

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical samples of `{an,seg}` required before a capture. Must be ≥2.
- `TIMEOUT`, default 262144: cycles allowed without a completed frame before a `timeout` is raised. Must be > 4·STABLE_CYCLES.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-high; the only reset in the block.
- `seg`  in  7  segment lines, bit order `{g,f,e,d,c,b,a}`, active low (0 = lit).
- `an`  in  4  anode selects, active low; `an[i]`=0 selects digit i.
- `digit3`, `digit2`, `digit1`, `digit0`  out  4 each  last decoded value per position.
- `valid`  out  4  `valid[i]`=1: `digit_i` holds a legal hex glyph captured since the last reset or timeout.
- `blank`  out  4  `blank[i]`=1: the last capture for position i was all segments off.
- `frame_done`  out  1  one-cycle pulse when all four positions have been captured since the previous pulse.
- `glyph_err`  out  1  one-cycle pulse when a stable capture holds an illegal segment pattern.
- `timeout`  out  1  one-cycle pulse on a refresh stall.

## Operation
- Input register: `{an,seg}` is registered into `in_q` every cycle; all later logic uses `in_q` only.
- Stability counter `cnt`, width $clog2(STABLE_CYCLES):
  - if `in_q` changes from its previous value: `cnt`←0 and `armed`←1;
  - otherwise `cnt` increments, saturating at STABLE_CYCLES-1.
- Capture condition: `armed`=1, `cnt`==STABLE_CYCLES-1, and `in_q.an` is exactly one-hot-low.
  - On capture: `armed`←0, so there is one capture per stable window.
  - If `an` is 4'b1111 or has more than one bit low, no capture happens, `armed` stays 1 and there is no error.
- Decode of a capture at position i, `seg` converted to abcdefg order `{a..g}`:
  - Legal glyph: `digit_i`←nibble, `valid[i]`←1, `blank[i]`←0.
  - Glyph table (abcdefg): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - 1111111: `blank[i]`←1, `valid[i]`←0, `digit_i` unchanged.
  - Any other pattern: `glyph_err` pulses, `valid[i]`←0, `blank[i]`←0, `digit_i` unchanged.
- Frame tracking: a `seen` mask sets bit i on every capture, whether legal, blank or illegal.
  - When `seen | capture_bit` == 4'b1111, `frame_done` pulses on that same edge and `seen`←0.
  - Recapturing the same position before the frame completes is harmless.
- Stall watchdog: counter `tcnt` increments every cycle.
  - It resets to 0 on `frame_done`.
  - When it reaches TIMEOUT-1: `timeout` pulses, `valid`←0, `seen`←0 and `tcnt`←0. `digit*` and `blank` hold their values.

## Timing
- Reset values (next edge with `rst`=1, including mid-operation):
  - outputs: `digit*`=0, `valid`=0, `blank`=0, `frame_done`=0, `glyph_err`=0, `timeout`=0;
  - internal state: `in_q`=7'h7F/4'hF, `cnt`=0, `armed`=0, `seen`=0, `tcnt`=0.
- Latency: a new pin value first sampled into `in_q` at edge k updates the outputs at edge k+STABLE_CYCLES, provided it is unchanged through that edge.
- `frame_done` and `glyph_err` fire on the same edge as the capture that causes them.
- If `frame_done` and the watchdog expiry coincide on one edge, `frame_done` wins: no `timeout`, and `tcnt`←0.
- Any change in `in_q` before `cnt` reaches STABLE_CYCLES-1 discards the window; partial windows never capture.
- After capture, a static input produces no further captures until `in_q` changes.

## Structure
- Shared package `ssd_pkg`: the 16 glyph constants in abcdefg order, `SSD_BLANK`=7'b1111111, and a helper ordering function `{g..a}`↔`{a..g}`. The encode side of the codebase uses the same constants.
- Sub-module `ssd_glyph_decode`: purely combinational. Inputs: abcdefg. Outputs: nibble[3:0], `legal`, `is_blank`.

## Test plan
- Static drive with STABLE_CYCLES=4: `an`=4'b1110, `seg` for "A" ({g..a}=7'b0001000 reversed from abcdefg 0001000) → `digit0`=4'hA and `valid`=4'b0001 exactly 4 edges after `in_q` updates; no second capture.
- Rotating controller model showing 1,2,3,F on digits 0..3, 64 cycles per phase → `frame_done` pulses once per 256 cycles; `digit3..0`=F,3,2,1; `valid`=4'hF; `blank`=0.
- Glitch: `seg` toggles every 2 cycles with STABLE_CYCLES=4 → no capture, outputs unchanged, no pulses.
- Illegal glyph abcdefg=1111110 on digit2 → `glyph_err` pulses once, `valid[2]`=0, `digit2` holds its prior value; blank pattern on digit1 → `blank[1]`=1.
- Stall: refresh stops with TIMEOUT=1000 → `timeout` pulses 1000 cycles after the last `frame_done`, `valid`=0, digits hold; coincident-edge case → only `frame_done`.
- Assert `rst` mid-window and mid-frame → all outputs 0 next edge; the first capture after release needs a full STABLE_CYCLES window.
